// File: rtl/i2s_frame_sequencer_if.sv
// Sample/control bundle between the synth engine, the I2S frame sequencer
// and the downstream serializer. The master modport is the sequencer side.
interface i2s_frame_sequencer_if #(
   parameter int unsigned AUD_BIT_DEPTH = 24
);
   logic                     run_en;
   logic                     sample_valid;
   logic [AUD_BIT_DEPTH-1:0] i_lsample;
   logic [AUD_BIT_DEPTH-1:0] i_rsample;
   logic                     oAUD_BCLK;
   logic                     oAUD_DACLRCK;
   logic                     o_sample_req;
   logic                     o_i2s_enable;
   logic [AUD_BIT_DEPTH-1:0] o_lsound_out;
   logic [AUD_BIT_DEPTH-1:0] o_rsound_out;
   logic [7:0]               o_underrun_cnt;

   modport master (
      input  run_en, sample_valid, i_lsample, i_rsample,
      output oAUD_BCLK, oAUD_DACLRCK, o_sample_req, o_i2s_enable,
             o_lsound_out, o_rsound_out, o_underrun_cnt
   );

   modport slave (
      output run_en, sample_valid, i_lsample, i_rsample,
      input  oAUD_BCLK, oAUD_DACLRCK, o_sample_req, o_i2s_enable,
             o_lsound_out, o_rsound_out, o_underrun_cnt
   );
endinterface

// File: rtl/i2s_frame_sequencer.sv
// Master-mode I2S timing generator and per-frame stereo sample scheduler.
// Generates BCLK/DACLRCK from iCLK, requests one L/R pair per 64-bit frame,
// and holds the serializer disabled until START_FRAMES good frames are seen.
// Optional build macro I2S_UNDERRUN_MUTE_EN: an underrun zeroes the pending
// pair (missed frame is silent) instead of repeating the previous pair.
module i2s_frame_sequencer #(
   parameter int unsigned AUD_BIT_DEPTH = 24,
   parameter int unsigned BCLK_HALF_DIV = 4,
   parameter int unsigned START_FRAMES  = 2
) (
   input  logic                  iCLK,
   input  logic                  reset_reg,
   i2s_frame_sequencer_if.master bus
);

   localparam int unsigned     DivW     = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
   localparam logic [DivW-1:0] DivLast  = DivW'(BCLK_HALF_DIV - 1);
   localparam logic [3:0]      StartCnt = 4'(START_FRAMES);

   typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

   logic [DivW-1:0]          divcnt_q, divcnt_d;
   logic                     bclk_q, bclk_d;
   logic [5:0]               bitcnt_q, bitcnt_d;
   logic                     lrck_q, lrck_d;
   state_e                   state_q, state_d;
   logic [3:0]               goodcnt_q, goodcnt_d;
   logic                     en_q, en_d;
   logic                     req_q, req_d;
   logic [7:0]               ucnt_q, ucnt_d;
   logic [AUD_BIT_DEPTH-1:0] pend_l_q, pend_l_d;
   logic [AUD_BIT_DEPTH-1:0] pend_r_q, pend_r_d;
   logic [AUD_BIT_DEPTH-1:0] rstage_q, rstage_d;
   logic [AUD_BIT_DEPTH-1:0] lsound_q, lsound_d;
   logic [AUD_BIT_DEPTH-1:0] rsound_q, rsound_d;

   logic       fall_stb;
   logic [5:0] bitcnt_nxt;
   logic       frame_start;
   logic       deadline;
   logic       slot_r;
   logic       accept;
   logic       underrun;

   // Slot-position strobes, all keyed to the BCLK falling transition.
   assign fall_stb    = (divcnt_q == DivLast) && bclk_q;
   assign bitcnt_nxt  = bitcnt_q + 6'd1;
   assign frame_start = fall_stb && (bitcnt_nxt == 6'd0);
   assign deadline    = fall_stb && (bitcnt_nxt == 6'd48);
   assign slot_r      = fall_stb && (bitcnt_nxt == 6'd16);
   assign accept      = bus.sample_valid && req_q;
   // A valid arriving on the deadline clock itself still counts as accepted.
   assign underrun    = deadline && req_q && !bus.sample_valid;

   // Bit clock divider, bit counter and LR clock next-state.
   always_comb begin
      divcnt_d = divcnt_q;
      bclk_d   = bclk_q;
      bitcnt_d = bitcnt_q;
      lrck_d   = lrck_q;
      if (divcnt_q == DivLast) begin
         divcnt_d = '0;
         bclk_d   = ~bclk_q;
      end else begin
         divcnt_d = divcnt_q + 1'b1;
      end
      if (fall_stb) begin
         bitcnt_d = bitcnt_nxt;
         lrck_d   = bitcnt_nxt[5];
      end
   end

   // Clock generation state; free-running whenever reset is released.
   always_ff @(posedge iCLK or posedge reset_reg) begin
      if (reset_reg) begin
         divcnt_q <= '0;
         bclk_q   <= 1'b0;
         bitcnt_q <= 6'd63;
         lrck_q   <= 1'b1;
      end else begin
         divcnt_q <= divcnt_d;
         bclk_q   <= bclk_d;
         bitcnt_q <= bitcnt_d;
         lrck_q   <= lrck_d;
      end
   end

   // Streaming FSM next-state: priming count and frame-aligned transitions.
   always_comb begin
      state_d   = state_q;
      goodcnt_d = goodcnt_q;
      if (state_q == StPrime) begin
         if (accept && (goodcnt_q != 4'hF)) begin
            goodcnt_d = goodcnt_q + 4'd1;
         end else if (underrun) begin
            goodcnt_d = '0;
         end
      end
      if (frame_start) begin
         unique case (state_q)
            StIdle: begin
               if (bus.run_en) begin
                  state_d   = StPrime;
                  goodcnt_d = '0;
               end
            end
            StPrime: begin
               if (!bus.run_en) begin
                  state_d = StIdle;
               end else if (goodcnt_q == StartCnt) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (!bus.run_en) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      en_d = (state_d == StRun);
   end

   // FSM state and serializer enable.
   always_ff @(posedge iCLK or posedge reset_reg) begin
      if (reset_reg) begin
         state_q   <= StIdle;
         goodcnt_q <= '0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         goodcnt_q <= goodcnt_d;
         en_q      <= en_d;
      end
   end

   // Request handshake, underrun accounting and frame-aligned output words.
   always_comb begin
      req_d    = req_q;
      ucnt_d   = ucnt_q;
      pend_l_d = pend_l_q;
      pend_r_d = pend_r_q;
      rstage_d = rstage_q;
      lsound_d = lsound_q;
      rsound_d = rsound_q;
      if (accept) begin
         pend_l_d = bus.i_lsample;
         pend_r_d = bus.i_rsample;
         req_d    = 1'b0;
      end else if (underrun) begin
         req_d = 1'b0;
`ifdef I2S_UNDERRUN_MUTE_EN
         pend_l_d = '0;
         pend_r_d = '0;
`else
         pend_l_d = pend_l_q;
         pend_r_d = pend_r_q;
`endif
         if (ucnt_q != 8'hFF) begin
            ucnt_d = ucnt_q + 8'd1;
         end
      end
      if (frame_start) begin
         req_d = (state_d != StIdle);
      end
      // Left word and the staged right word are taken together from the value
      // pending after this clock, so a late accept or a mute lands in both.
      // The right word is staged because the next request may refill the
      // pending pair before the right slot of the following frame.
      if (deadline) begin
         lsound_d = pend_l_d;
         rstage_d = pend_r_d;
      end
      if (slot_r) begin
         rsound_d = rstage_q;
      end
   end

   // Handshake and sample data registers.
   always_ff @(posedge iCLK or posedge reset_reg) begin
      if (reset_reg) begin
         req_q    <= 1'b0;
         ucnt_q   <= '0;
         pend_l_q <= '0;
         pend_r_q <= '0;
         rstage_q <= '0;
         lsound_q <= '0;
         rsound_q <= '0;
      end else begin
         req_q    <= req_d;
         ucnt_q   <= ucnt_d;
         pend_l_q <= pend_l_d;
         pend_r_q <= pend_r_d;
         rstage_q <= rstage_d;
         lsound_q <= lsound_d;
         rsound_q <= rsound_d;
      end
   end

   assign bus.oAUD_BCLK      = bclk_q;
   assign bus.oAUD_DACLRCK   = lrck_q;
   assign bus.o_sample_req   = req_q;
   assign bus.o_i2s_enable   = en_q;
   assign bus.o_lsound_out   = lsound_q;
   assign bus.o_rsound_out   = rsound_q;
   assign bus.o_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Self-checking bench for i2s_frame_sequencer: frame-by-frame vector table on a
// DIV=4 instance plus hand-written reset, restart and saturation sequences
// (saturation on a DIV=1 instance to keep the run short).
module tb_i2s_frame_sequencer;

   localparam int W = 24;
`ifdef I2S_UNDERRUN_MUTE_EN
   localparam bit Mute = 1'b1;
`else
   localparam bit Mute = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2s_frame_sequencer_if #(.AUD_BIT_DEPTH(W)) bus ();
   i2s_frame_sequencer_if #(.AUD_BIT_DEPTH(W)) bus_s ();

   i2s_frame_sequencer #(.AUD_BIT_DEPTH(W), .BCLK_HALF_DIV(4), .START_FRAMES(2)) u_dut (
      .iCLK      (clk),
      .reset_reg (rst),
      .bus       (bus)
   );

   i2s_frame_sequencer #(.AUD_BIT_DEPTH(W), .BCLK_HALF_DIV(1), .START_FRAMES(2)) u_sat (
      .iCLK      (clk),
      .reset_reg (rst),
      .bus       (bus_s)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          resp;
      int          dly;
      logic [23:0] l;
      logic [23:0] r;
      bit          junk;
      bit          run_next;
      logic        exp_en;
      logic        exp_req;
      logic [23:0] exp_r16;
      logic [23:0] exp_l48;
      logic [7:0]  exp_cnt;
   } frame_t;

   frame_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Wait for a DACLRCK falling edge (frame start), bounded.
   task automatic wait_frame(input string tag);
      logic prev;
      bit   found;
      found = 1'b0;
      prev  = bus.oAUD_DACLRCK;
      for (int k = 0; k < 600 && !found; k++) begin
         wait_clks(1);
         if (prev && !bus.oAUD_DACLRCK) found = 1'b1;
         prev = bus.oAUD_DACLRCK;
      end
      check({"frame_start_", tag}, 32'(found), 32'd1);
   endtask

   function automatic frame_t mk(input bit resp, input int dly, input logic [23:0] l,
                                 input logic [23:0] r, input bit junk, input bit run_next,
                                 input logic en, input logic req, input logic [23:0] r16,
                                 input logic [23:0] l48, input logic [7:0] cnt);
      frame_t f;
      f.resp = resp; f.dly = dly; f.l = l; f.r = r; f.junk = junk; f.run_next = run_next;
      f.exp_en = en; f.exp_req = req; f.exp_r16 = r16; f.exp_l48 = l48; f.exp_cnt = cnt;
      return f;
   endfunction

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] l1, r1, l2, r2, l3, r3, l2u, r2u;
      int n;
      bit ok;
      l1 = 24'h123456; r1 = 24'hABCDEF;
      l2 = 24'h654321; r2 = 24'h0FEDCB;
      l3 = 24'h00AA55; r3 = 24'hFF00FF;
      l2u = Mute ? 24'h0 : l2;
      r2u = Mute ? 24'h0 : r2;

      //            resp dly  l   r   junk run | en req r16  l48  cnt
      tbl[0]  = mk(1, 10,  l1, r1, 0, 1, 0, 1, 24'h0, l1,  8'd0);
      tbl[1]  = mk(1, 10,  l1, r1, 0, 1, 0, 1, r1,    l1,  8'd0);
      tbl[2]  = mk(1, 10,  l2, r2, 0, 1, 1, 1, r1,    l2,  8'd0);
      tbl[3]  = mk(0, 0,   0,  0,  0, 1, 1, 1, r2,    l2u, 8'd1);
      tbl[4]  = mk(1, 10,  l3, r3, 0, 1, 1, 1, r2u,   l3,  8'd1);
      tbl[5]  = mk(1, 10,  l1, r1, 1, 0, 1, 1, r3,    l1,  8'd1);
      tbl[6]  = mk(0, 0,   0,  0,  0, 1, 0, 0, r1,    l1,  8'd1);
      tbl[7]  = mk(1, 10,  l2, r2, 0, 1, 0, 1, r1,    l2,  8'd1);
      tbl[8]  = mk(0, 0,   0,  0,  0, 1, 0, 1, r2,    l2u, 8'd2);
      tbl[9]  = mk(1, 10,  l3, r3, 0, 1, 0, 1, r2u,   l3,  8'd2);
      tbl[10] = mk(1, 10,  l1, r1, 0, 1, 0, 1, r3,    l1,  8'd2);
      tbl[11] = mk(1, 10,  l2, r2, 0, 1, 1, 1, r1,    l2,  8'd2);
      tbl[12] = mk(1, 383, l3, r3, 0, 1, 1, 1, r2,    l3,  8'd2);
      tbl[13] = mk(1, 10,  l1, r1, 0, 1, 1, 1, r3,    l1,  8'd2);

      bus.run_en = 1'b0; bus.sample_valid = 1'b0; bus.i_lsample = '0; bus.i_rsample = '0;
      bus_s.run_en = 1'b1; bus_s.sample_valid = 1'b0;
      bus_s.i_lsample = '0; bus_s.i_rsample = '0;

      // Reset values while held, then BCLK/LRCK timing after release.
      rst = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_bclk", 32'(bus.oAUD_BCLK), 32'd0);
      check("rst_lrck", 32'(bus.oAUD_DACLRCK), 32'd1);
      check("rst_req", 32'(bus.o_sample_req), 32'd0);
      check("rst_en", 32'(bus.o_i2s_enable), 32'd0);
      check("rst_l", 32'(bus.o_lsound_out), 32'd0);
      check("rst_r", 32'(bus.o_rsound_out), 32'd0);
      check("rst_cnt", 32'(bus.o_underrun_cnt), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         wait_clks(1);
         check($sformatf("bclk_k%0d", k), 32'(bus.oAUD_BCLK), 32'((k / 4) % 2));
         check($sformatf("lrck_k%0d", k), 32'(bus.oAUD_DACLRCK), 32'(k < 8));
      end
      bus.run_en = 1'b1;
      n = 0;
      while (bus.oAUD_DACLRCK == 1'b0 && n < 600) begin
         wait_clks(1);
         n++;
      end
      check("lrck_low_clks", 32'(n + 8), 32'd256);
      n = 0;
      while (bus.oAUD_DACLRCK == 1'b1 && n < 600) begin
         wait_clks(1);
         n++;
      end
      check("lrck_high_clks", 32'(n), 32'd256);

      // Frame table: each entry starts at the negedge after a frame start.
      for (int i = 0; i < 14; i++) begin
         if (i > 0) wait_frame($sformatf("f%0d", i));
         for (int t = 0; t <= 384; t++) begin
            if (t == 0) begin
               check($sformatf("f%0d_en", i), 32'(bus.o_i2s_enable), 32'(tbl[i].exp_en));
               check($sformatf("f%0d_req", i), 32'(bus.o_sample_req), 32'(tbl[i].exp_req));
            end
            if (tbl[i].resp && t == tbl[i].dly) begin
               bus.sample_valid = 1'b1;
               bus.i_lsample = tbl[i].l;
               bus.i_rsample = tbl[i].r;
            end
            if (tbl[i].junk && t == 50) begin
               bus.sample_valid = 1'b1;
               bus.i_lsample = 24'h111111;
               bus.i_rsample = 24'h222222;
            end
            if ((tbl[i].resp && t == tbl[i].dly + 1) || (tbl[i].junk && t == 51)) begin
               bus.sample_valid = 1'b0;
            end
            if (tbl[i].resp && tbl[i].dly == 10 && t == 11) begin
               check($sformatf("f%0d_req_drop", i), 32'(bus.o_sample_req), 32'd0);
            end
            if (t == 128) begin
               check($sformatf("f%0d_r16", i), 32'(bus.o_rsound_out), 32'(tbl[i].exp_r16));
            end
            if (t == 160) bus.run_en = tbl[i].run_next;
            if (t == 384) begin
               check($sformatf("f%0d_l48", i), 32'(bus.o_lsound_out), 32'(tbl[i].exp_l48));
               check($sformatf("f%0d_cnt", i), 32'(bus.o_underrun_cnt), 32'(tbl[i].exp_cnt));
               check($sformatf("f%0d_req48", i), 32'(bus.o_sample_req), 32'd0);
            end
            if (t < 384) wait_clks(1);
         end
      end

      // Reset mid-frame at bitcnt 40 while running, then clean restart.
      wait_frame("pre_reset");
      check("run_before_reset", 32'(bus.o_i2s_enable), 32'd1);
      wait_clks(320);
      rst = 1'b1;
      #1;
      check("mid_rst_en", 32'(bus.o_i2s_enable), 32'd0);
      check("mid_rst_req", 32'(bus.o_sample_req), 32'd0);
      check("mid_rst_l", 32'(bus.o_lsound_out), 32'd0);
      check("mid_rst_r", 32'(bus.o_rsound_out), 32'd0);
      check("mid_rst_cnt", 32'(bus.o_underrun_cnt), 32'd0);
      check("mid_rst_bclk", 32'(bus.oAUD_BCLK), 32'd0);
      check("mid_rst_lrck", 32'(bus.oAUD_DACLRCK), 32'd1);
      wait_clks(2);
      rst = 1'b0;
      wait_clks(7);
      check("restart_lrck_k7", 32'(bus.oAUD_DACLRCK), 32'd1);
      check("restart_req_k7", 32'(bus.o_sample_req), 32'd0);
      wait_clks(1);
      check("restart_lrck_k8", 32'(bus.oAUD_DACLRCK), 32'd0);
      check("restart_req_k8", 32'(bus.o_sample_req), 32'd1);
      check("restart_en_k8", 32'(bus.o_i2s_enable), 32'd0);

      // Saturation: DIV=1 instance streams with no responses at all.
      rst = 1'b1;
      wait_clks(2);
      rst = 1'b0;
      ok = 1'b1;
      for (int k = 1; k <= 260 && ok; k++) begin
         n = 0;
         while (bus_s.o_sample_req == 1'b0 && n < 300) begin
            wait_clks(1);
            n++;
         end
         if (n >= 300) ok = 1'b0;
         n = 0;
         while (ok && bus_s.o_sample_req == 1'b1 && n < 300) begin
            wait_clks(1);
            n++;
         end
         if (n >= 300) ok = 1'b0;
         if (ok && (k == 1 || k == 128 || k == 254 || k == 255 || k == 260)) begin
            check($sformatf("sat_cnt_k%0d", k), 32'(bus_s.o_underrun_cnt),
                  32'((k > 255) ? 255 : k));
         end
      end
      check("sat_req_handshake_seen", 32'(ok), 32'd1);
      check("sat_l_untouched", 32'(bus_s.o_lsound_out), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
